// File: rtl/wb_csr_pkg.sv
// Shared types and helpers for the Wishbone CSR bank.
package wb_csr_pkg;

  localparam int unsigned DW = 32;
  localparam int unsigned NB = DW / 8;

  localparam logic [2:0] CTI_CLASSIC = 3'b000;
  localparam logic [2:0] CTI_CONST   = 3'b001;
  localparam logic [2:0] CTI_INCR    = 3'b010;
  localparam logic [2:0] CTI_EOB     = 3'b111;

  localparam logic [1:0] BTE_LINEAR = 2'b00;
  localparam logic [1:0] BTE_WRAP4  = 2'b01;
  localparam logic [1:0] BTE_WRAP8  = 2'b10;
  localparam logic [1:0] BTE_WRAP16 = 2'b11;

  typedef enum logic [1:0] {IDLE, SINGLE, BURST, ERR} state_e;

  // Word address lies inside the RW or RO window.
  function automatic logic is_mapped(input logic [31:0] a, input int unsigned n_rw,
                                     input int unsigned n_ro);
    return a < 32'(n_rw + n_ro);
  endfunction

  // Cycle types 011..110 are not supported and terminate with an error.
  function automatic logic cti_reserved(input logic [2:0] cti);
    return (cti >= 3'b011) && (cti <= 3'b110);
  endfunction

endpackage

// File: rtl/wb_csr_addr_gen.sv
// Next burst word address for constant, linear and wrapping bursts.
module wb_csr_addr_gen
  import wb_csr_pkg::*;
#(
  parameter int unsigned AW = 10
) (
  input  logic [AW-1:0] addr,
  input  logic [2:0]    cti,
  input  logic [1:0]    bte,
  output logic [AW-1:0] next_addr_c
);

  logic [AW-1:0] inc;
  logic [AW-1:0] mask;

  // Wrapping bursts only advance the low bits selected by mask.
  always_comb begin
    inc = addr + AW'(1);
    mask = '1;
    case (bte)
      BTE_LINEAR: mask = '1;
      BTE_WRAP4:  mask = AW'(3);
      BTE_WRAP8:  mask = AW'(7);
      BTE_WRAP16: mask = AW'(15);
    endcase
    next_addr_c = (cti == CTI_INCR) ? ((addr & ~mask) | (inc & mask)) : addr;
  end

endmodule

// File: rtl/wb_csr_bank.sv
// Wishbone B4 CSR bank: byte-writable RW registers, RO status inputs,
// registered-feedback bursts, pulse bits and error termination.
module wb_csr_bank
  import wb_csr_pkg::*;
#(
  parameter int unsigned N_RW = 8,
  parameter int unsigned N_RO = 8,
  parameter int unsigned AW = 10,
  parameter logic [N_RW*32-1:0] RW_RESET = '0,
  parameter logic [N_RW*32-1:0] PULSE_MASK = '0
) (
  input  logic                 clk_i,
  input  logic                 reset_n_i,
  input  logic                 cyc_i,
  input  logic                 stb_i,
  input  logic                 we_i,
  input  logic [31:0]          adr_i,
  input  logic [3:0]           sel_i,
  input  logic [31:0]          dat_i,
  input  logic [2:0]           cti_i,
  input  logic [1:0]           bte_i,
  output logic [31:0]          dat_o,
  output logic                 ack_o,
  output logic                 err_o,
  output logic                 rty_o,
  output logic [N_RW*32-1:0]   rw_o,
  input  logic [N_RO*32-1:0]   ro_i,
  output logic [N_RW-1:0]      wr_stb_o,
  output logic [N_RO-1:0]      rd_stb_o
);

  state_e        state;
  logic [AW-1:0] addr;
  logic [AW-1:0] next_addr;
  logic [AW-1:0] load_addr;
  logic [DW-1:0] rd_data;
  logic [DW-1:0] rw_q [N_RW];
  logic [DW-1:0] rw_d [N_RW];
  logic [N_RW-1:0] wr_hit;
  logic [N_RO-1:0] rd_hit;
  logic          commit;
  logic          unused_adr;

  assign unused_adr = ^{adr_i[31:AW+2], adr_i[1:0]};
  assign rty_o = 1'b0;

  wb_csr_addr_gen #(.AW(AW)) u_addr_gen (
    .addr        (addr),
    .cti         (cti_i),
    .bte         (bte_i),
    .next_addr_c (next_addr)
  );

  // Read mux on the address about to be acknowledged, plus register next-state.
  always_comb begin
    load_addr = (state == IDLE) ? adr_i[AW+1:2] : next_addr;
    commit = ack_o & cyc_i & stb_i & we_i;
    rd_data = '0;
    rd_hit = '0;
    wr_hit = '0;
    for (int unsigned k = 0; k < N_RW; k++) begin
      if (load_addr == AW'(k)) rd_data = rw_q[k];
      rw_d[k] = rw_q[k] & ~PULSE_MASK[DW*k +: DW];
      if (commit && addr == AW'(k)) begin
        wr_hit[k] = 1'b1;
        for (int unsigned b = 0; b < NB; b++) begin
          if (sel_i[b]) rw_d[k][8*b +: 8] = dat_i[8*b +: 8];
        end
      end
    end
    for (int unsigned j = 0; j < N_RO; j++) begin
      if (load_addr == AW'(N_RW + j)) begin
        rd_data = ro_i[DW*j +: DW];
        rd_hit[j] = ~we_i;
      end
    end
  end

  always_comb begin
    for (int unsigned k = 0; k < N_RW; k++) rw_o[DW*k +: DW] = rw_q[k];
  end

  // Bus FSM; every output is a register updated here.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state <= IDLE;
      addr <= '0;
      dat_o <= '0;
      ack_o <= 1'b0;
      err_o <= 1'b0;
      wr_stb_o <= '0;
      rd_stb_o <= '0;
      for (int unsigned k = 0; k < N_RW; k++) rw_q[k] <= RW_RESET[DW*k +: DW];
    end else begin
      ack_o <= 1'b0;
      err_o <= 1'b0;
      rd_stb_o <= '0;
      wr_stb_o <= wr_hit;
      for (int unsigned k = 0; k < N_RW; k++) rw_q[k] <= rw_d[k];
      case (state)
        IDLE: begin
          if (cyc_i && stb_i) begin
            addr <= load_addr;
            if (!is_mapped(32'(load_addr), N_RW, N_RO) || cti_reserved(cti_i)) begin
              state <= ERR;
              err_o <= 1'b1;
            end else begin
              state <= (cti_i == CTI_CLASSIC || cti_i == CTI_EOB) ? SINGLE : BURST;
              ack_o <= 1'b1;
              dat_o <= rd_data;
              rd_stb_o <= rd_hit;
            end
          end
        end
        SINGLE: state <= IDLE;
        BURST: begin
          if (cti_i == CTI_EOB || !stb_i || !cyc_i) begin
            state <= IDLE;
          end else if (!is_mapped(32'(next_addr), N_RW, N_RO)) begin
            state <= ERR;
            err_o <= 1'b1;
            addr <= next_addr;
          end else begin
            addr <= next_addr;
            ack_o <= 1'b1;
            dat_o <= rd_data;
            rd_stb_o <= rd_hit;
          end
        end
        ERR: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_wb_csr_bank.sv
// Directed scoreboard bench for wb_csr_bank.
module tb_wb_csr_bank;
  import wb_csr_pkg::*;

  localparam int unsigned N_RW = 8;
  localparam int unsigned N_RO = 8;
  localparam int unsigned AW = 10;
  localparam logic [255:0] TB_RWR = 256'(32'h1234_5678) << 160;
  localparam logic [255:0] TB_PM = 256'(1) << 64;

  typedef struct packed {
    logic        is_err;
    logic        chk;
    logic [31:0] data;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n;
  logic cyc, stb, we;
  logic [31:0] adr, dat, dat_o;
  logic [3:0] sel;
  logic [2:0] cti;
  logic [1:0] bte;
  logic ack_o, err_o, rty_o;
  logic [255:0] rw_o, ro;
  logic [7:0] wr_stb_o, rd_stb_o;

  exp_t exp_q[$];
  int compared = 0;
  int mism = 0;
  logic [31:0] mrw[8];
  logic [31:0] mro[8];

  always #5 clk = ~clk;

  wb_csr_bank #(.N_RW(N_RW), .N_RO(N_RO), .AW(AW), .RW_RESET(TB_RWR), .PULSE_MASK(TB_PM)) dut (
    .clk_i(clk), .reset_n_i(rst_n), .cyc_i(cyc), .stb_i(stb), .we_i(we), .adr_i(adr),
    .sel_i(sel), .dat_i(dat), .cti_i(cti), .bte_i(bte), .dat_o(dat_o), .ack_o(ack_o),
    .err_o(err_o), .rty_o(rty_o), .rw_o(rw_o), .ro_i(ro), .wr_stb_o(wr_stb_o),
    .rd_stb_o(rd_stb_o)
  );

  function automatic logic [255:0] model_rw();
    logic [255:0] v;
    for (int k = 0; k < 8; k++) v[32*k +: 32] = mrw[k];
    return v;
  endfunction

  task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] expv);
    compared++;
    assert (obs === expv) else begin
      mism++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic push(input logic e, input logic c, input logic [31:0] d);
    exp_q.push_back('{is_err: e, chk: c, data: d});
  endtask

  task automatic pop_check(input string tag);
    exp_t e;
    check({tag, "_sb"}, 256'(exp_q.size() != 0), 256'(1));
    if (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      check({tag, "_term"}, 256'({ack_o, err_o}), e.is_err ? 256'(2'b01) : 256'(2'b10));
      if (e.chk) check({tag, "_data"}, 256'(dat_o), 256'(e.data));
    end
  endtask

  task automatic bus_idle();
    cyc = 1'b0; stb = 1'b0; we = 1'b0; cti = 3'b000; bte = 2'b00; sel = 4'h0;
  endtask

  task automatic single(input string tag, input logic t_we, input logic [31:0] t_a,
                        input logic [3:0] t_sel, input logic [31:0] t_d,
                        input logic [2:0] t_cti, output logic [7:0] rds);
    int lat;
    logic done;
    cyc = 1'b1; stb = 1'b1; we = t_we; adr = t_a; sel = t_sel; dat = t_d;
    cti = t_cti; bte = 2'b00;
    lat = 0;
    done = 1'b0;
    while (!done && lat < 8) begin
      @(posedge clk); #1;
      lat++;
      done = ack_o | err_o;
    end
    check({tag, "_lat"}, 256'(lat), 256'(1));
    rds = rd_stb_o;
    if (done) pop_check(tag);
    @(posedge clk); #1;
    bus_idle();
    check({tag, "_once"}, 256'({ack_o, err_o}), 256'(0));
  endtask

  task automatic burst(input string tag, input logic t_we, input logic [31:0] t_a,
                       input logic [2:0] mode, input logic [1:0] t_bte, input int n,
                       input logic [31:0] wd[4]);
    int b, gap;
    logic stop;
    cyc = 1'b1; stb = 1'b1; we = t_we; adr = t_a; sel = 4'hf; dat = wd[0];
    cti = mode; bte = t_bte;
    b = 0; gap = 0; stop = 1'b0;
    for (int i = 0; i < n + 6 && !stop; i++) begin
      @(posedge clk); #1;
      gap++;
      if (err_o) begin
        pop_check({tag, "_err"});
        stop = 1'b1;
      end else if (ack_o) begin
        check($sformatf("%s_gap%0d", tag, b), 256'(gap), 256'(1));
        gap = 0;
        pop_check($sformatf("%s_b%0d", tag, b));
        dat = wd[b];
        cti = (b == n - 1) ? CTI_EOB : mode;
        b++;
        if (b == n) stop = 1'b1;
      end
    end
    check({tag, "_done"}, 256'(stop), 256'(1));
    @(posedge clk); #1;
    bus_idle();
    check({tag, "_once"}, 256'({ack_o, err_o}), 256'(0));
  endtask

  initial begin
    logic [7:0] rds;
    logic [31:0] wd[4];
    rst_n = 1'b0;
    adr = '0; dat = '0;
    bus_idle();
    for (int k = 0; k < 8; k++) mrw[k] = '0;
    mrw[5] = 32'h1234_5678;
    for (int j = 0; j < 8; j++) begin
      mro[j] = 32'hC0DE_0000 | 32'(j);
      ro[32*j +: 32] = mro[j];
    end
    wd[0] = '0; wd[1] = '0; wd[2] = '0; wd[3] = '0;

    repeat (2) @(posedge clk);
    #1;
    check("rst_ack", 256'(ack_o), 256'(0));
    check("rst_err", 256'(err_o), 256'(0));
    check("rst_rty", 256'(rty_o), 256'(0));
    check("rst_dat", 256'(dat_o), 256'(0));
    check("rst_wrstb", 256'(wr_stb_o), 256'(0));
    check("rst_rdstb", 256'(rd_stb_o), 256'(0));
    check("rst_rw", rw_o, TB_RWR);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;

    // Byte-lane write to word 2; bit 0 is a pulse bit and clears a cycle later.
    push(1'b0, 1'b0, '0);
    single("wr2", 1'b1, 32'h08, 4'b0101, 32'hDEAD_BEEF, CTI_CLASSIC, rds);
    mrw[2] = 32'h00AD_00EF;
    check("wr2_rw", rw_o, model_rw());
    check("wr2_stb", 256'(wr_stb_o), 256'(8'h04));
    @(posedge clk); #1;
    mrw[2] = 32'h00AD_00EE;
    check("wr2_rw_clr", rw_o, model_rw());
    check("wr2_stb_off", 256'(wr_stb_o), 256'(0));

    push(1'b0, 1'b1, 32'h00AD_00EE);
    single("rd2", 1'b0, 32'h08, 4'hf, '0, CTI_CLASSIC, rds);

    mrw[0] = 32'h1111_1111; mrw[1] = 32'h2222_2222; mrw[3] = 32'h3333_3333;
    for (int k = 0; k < 4; k++) begin
      if (k != 2) begin
        push(1'b0, 1'b0, '0);
        single($sformatf("wr%0d", k), 1'b1, 32'(4 * k), 4'hf, mrw[k], CTI_CLASSIC, rds);
      end
    end
    check("wr013_rw", rw_o, model_rw());

    // Wrap-4 incrementing read burst from word 2.
    push(1'b0, 1'b1, mrw[2]); push(1'b0, 1'b1, mrw[3]);
    push(1'b0, 1'b1, mrw[0]); push(1'b0, 1'b1, mrw[1]);
    burst("wrap4", 1'b0, 32'h08, CTI_INCR, BTE_WRAP4, 4, wd);

    push(1'b0, 1'b1, mro[0]);
    single("ro0", 1'b0, 32'h20, 4'hf, '0, CTI_CLASSIC, rds);
    check("ro0_rdstb", 256'(rds), 256'(8'h01));

    push(1'b1, 1'b0, '0);
    single("unmapped", 1'b1, 32'h40, 4'hf, 32'hFFFF_FFFF, CTI_CLASSIC, rds);
    check("unmapped_rw", rw_o, model_rw());

    push(1'b1, 1'b0, '0);
    single("cti011", 1'b1, 32'h04, 4'hf, 32'hFFFF_FFFF, 3'b011, rds);
    check("cti011_rw", rw_o, model_rw());
    check("cti011_stb", 256'(wr_stb_o), 256'(0));

    push(1'b0, 1'b0, '0);
    single("pulse", 1'b1, 32'h08, 4'hf, 32'h1, CTI_CLASSIC, rds);
    mrw[2] = 32'h1;
    check("pulse_hi", rw_o, model_rw());
    @(posedge clk); #1;
    mrw[2] = 32'h0;
    check("pulse_lo", rw_o, model_rw());

    // Back-to-back writes of the pulse bit: the second lands in the clearing cycle.
    wd[0] = 32'h1; wd[1] = 32'h1;
    push(1'b0, 1'b0, '0); push(1'b0, 1'b0, '0);
    burst("pulse_b2b", 1'b1, 32'h08, CTI_CONST, BTE_LINEAR, 2, wd);
    mrw[2] = 32'h1;
    check("pulse_b2b_hi", rw_o, model_rw());
    @(posedge clk); #1;
    mrw[2] = 32'h0;
    check("pulse_b2b_lo", rw_o, model_rw());

    push(1'b0, 1'b1, mro[6]); push(1'b0, 1'b1, mro[7]); push(1'b1, 1'b0, '0);
    burst("ovf", 1'b0, 32'h38, CTI_INCR, BTE_LINEAR, 4, wd);

    push(1'b0, 1'b0, '0);
    single("wr_ro", 1'b1, 32'h24, 4'hf, 32'hAAAA_5555, CTI_CLASSIC, rds);
    check("wr_ro_rw", rw_o, model_rw());
    check("wr_ro_stb", 256'(wr_stb_o), 256'(0));

    push(1'b0, 1'b0, '0);
    single("sel0", 1'b1, 32'h10, 4'h0, 32'hFFFF_FFFF, CTI_CLASSIC, rds);
    check("sel0_stb", 256'(wr_stb_o), 256'(8'h10));
    check("sel0_rw", rw_o, model_rw());

    // Asynchronous reset in the middle of a read burst.
    cyc = 1'b1; stb = 1'b1; we = 1'b0; adr = 32'h0; cti = CTI_INCR; bte = BTE_LINEAR;
    @(posedge clk); #1;
    check("mid_ack0", 256'(ack_o), 256'(1));
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    check("mid_rst_ack", 256'(ack_o), 256'(0));
    check("mid_rst_dat", 256'(dat_o), 256'(0));
    check("mid_rst_rdstb", 256'(rd_stb_o), 256'(0));
    check("mid_rst_rw", rw_o, TB_RWR);
    bus_idle();
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    for (int k = 0; k < 8; k++) mrw[k] = '0;
    mrw[5] = 32'h1234_5678;

    push(1'b0, 1'b1, 32'h1234_5678);
    single("post_rd5", 1'b0, 32'h14, 4'hf, '0, CTI_CLASSIC, rds);
    push(1'b0, 1'b1, 32'h0);
    single("post_rd2", 1'b0, 32'h08, 4'hf, '0, CTI_CLASSIC, rds);

    check("sb_empty", 256'(exp_q.size()), 256'(0));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mism);
    $finish;
  end

endmodule
